// File: rtl/cfg_pkg.sv
// cfg_pkg: shared frame geometry, write-sequence states and default timing
// for the serial configuration loader.
package cfg_pkg;
   localparam int FRAME_BITS = 18;
   localparam int ADR_BITS   = 2;
   localparam int DAT_BITS   = 16;
   localparam int CNT_BITS   = 5;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_SETUP_CYC   = 2;
   localparam int DEF_WR_CYC      = 2;
   localparam int DEF_HOLD_CYC    = 2;
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;
endpackage

// File: rtl/cfg_sync_edge.sv
// cfg_sync_edge: multi-flop synchroniser for an asynchronous pad input, with
// one-cycle rise/fall pulses taken against one extra flop.
module cfg_sync_edge #(
   parameter int   STAGES   = 2,
   parameter logic IDLE_LVL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);
   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {STAGES{IDLE_LVL}};
         prev_q <= IDLE_LVL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign q_o    = sync_q[STAGES-1];
   assign rise_o = q_o & ~prev_q;
   assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/cfg_spi_loader.sv
// cfg_spi_loader: captures 18-bit SPI frames (2b address, 16b data, MSB first)
// and replays each accepted frame as a timed setup/strobe/hold register write.
module cfg_spi_loader
   import cfg_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int SETUP_CYC   = DEF_SETUP_CYC,
   parameter int WR_CYC      = DEF_WR_CYC,
   parameter int HOLD_CYC    = DEF_HOLD_CYC
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                sclk_i,
   input  logic                csn_i,
   input  logic                mosi_i,
   output logic                reg_wr_o,
   output logic [ADR_BITS-1:0] reg_adr_o,
   output logic [DAT_BITS-1:0] reg_dat_o,
   output logic                busy_o,
   output logic                frame_err_o,
   output logic [7:0]          frame_cnt_o
);
   state_e                state_q, state_d;
   logic [3:0]            cyc_q, cyc_d, cyc_last;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d, shreg_nx;
   logic [CNT_BITS-1:0]   bitcnt_q, bitcnt_d, bitcnt_nx;
   logic [ADR_BITS-1:0]   adr_q, adr_d;
   logic [DAT_BITS-1:0]   dat_q, dat_d;
   logic [7:0]            fcnt_q, fcnt_d;
   logic                  drop_q, drop_d, wr_q, wr_d, err_q, err_d;
   logic                  sclk_s, sclk_rise, sclk_fall, csn_s, csn_rise, csn_fall;
   logic                  mosi_s, mosi_rise, mosi_fall, unused_ok;
   logic                  idle, shift, frame_end, accept;

   cfg_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sclk (
      .clk_i(clk_i), .rst_i(rst_i), .d_i(sclk_i),
      .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall));
   cfg_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_csn (
      .clk_i(clk_i), .rst_i(rst_i), .d_i(csn_i),
      .q_o(csn_s), .rise_o(csn_rise), .fall_o(csn_fall));
   cfg_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_mosi (
      .clk_i(clk_i), .rst_i(rst_i), .d_i(mosi_i),
      .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall));

   assign unused_ok = ^{sclk_s, sclk_fall, mosi_rise, mosi_fall};

   // A last sclk rise landing with csn rise still counts: shift before checking.
   assign idle      = (state_q == IDLE);
   assign shift     = idle & ~drop_q & sclk_rise & (~csn_s | csn_rise);
   assign shreg_nx  = shift ? {shreg_q[FRAME_BITS-2:0], mosi_s} : shreg_q;
   assign bitcnt_nx = (shift && bitcnt_q != '1) ? bitcnt_q + CNT_BITS'(1) : bitcnt_q;
   assign frame_end = idle & ~drop_q & csn_rise;
   assign accept    = frame_end & (bitcnt_nx == CNT_BITS'(FRAME_BITS));

   always_comb begin
      shreg_d  = (idle && csn_fall) ? '0 : shreg_nx;
      bitcnt_d = (idle && csn_fall) ? '0 : bitcnt_nx;
      drop_d   = (!idle && csn_fall) ? 1'b1 : csn_rise ? 1'b0 : drop_q;
      err_d    = (csn_rise & drop_q) | (frame_end & ~accept);
      adr_d    = accept ? shreg_nx[FRAME_BITS-1 -: ADR_BITS] : adr_q;
      dat_d    = accept ? shreg_nx[DAT_BITS-1:0] : dat_q;
      fcnt_d   = fcnt_q + {7'd0, accept};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cyc_q   <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
      end
   end

   always_comb begin
      cyc_last = state_q == SETUP  ? 4'(SETUP_CYC - 1) :
                 state_q == STROBE ? 4'(WR_CYC - 1)    : 4'(HOLD_CYC - 1);
      state_d  = state_q;
      cyc_d    = '0;
      if (idle)
         state_d = accept ? SETUP : IDLE;
      else if (cyc_q != cyc_last)
         cyc_d = cyc_q + 4'd1;
      else
         state_d = state_q == SETUP ? STROBE : state_q == STROBE ? HOLD : IDLE;
   end

   // Strobe is registered from the next state so it lines up with STROBE exactly.
   always_comb begin
      wr_d = (state_d == STROBE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shreg_q  <= '0;
         bitcnt_q <= '0;
         drop_q   <= 1'b0;
         err_q    <= 1'b0;
         wr_q     <= 1'b0;
         adr_q    <= '0;
         dat_q    <= '0;
         fcnt_q   <= '0;
      end else begin
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         drop_q   <= drop_d;
         err_q    <= err_d;
         wr_q     <= wr_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         fcnt_q   <= fcnt_d;
      end
   end

   assign reg_wr_o    = wr_q;
   assign reg_adr_o   = adr_q;
   assign reg_dat_o   = dat_q;
   assign busy_o      = ~idle;
   assign frame_err_o = err_q;
   assign frame_cnt_o = fcnt_q;
endmodule
